// File: rtl/config_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : config_loader
//  Description : Serial configuration-chain loader. Accepts WORD_WIDTH-bit
//                words from a host over valid/ready and shifts them LSB-first
//                into the fabric configuration chain (CLBs, connector boxes,
//                BLEs linked config_in -> config_out). Stops after exactly
//                CHAIN_LENGTH bits, reports done, and keeps the last
//                WORD_WIDTH bits seen at the chain tail for readback.
//
//  Ports       : clk          - block clock, also the chain's config_clk
//                rst_n        - asynchronous active-low reset
//                start        - load request (honoured in IDLE/DONE only)
//                abort        - cancel load, wins over start
//                word_in      - configuration word, bit 0 shifted first
//                word_valid   - word_in is valid
//                word_ready   - word_in is accepted this cycle
//                config_data  - chain head data (config_in)
//                config_en    - chain shift enable
//                chain_out    - chain tail data (final config_out)
//                busy         - loading
//                done         - CHAIN_LENGTH bits have been shifted
//                bit_count    - bits shifted in current or last load
//                readback     - last WORD_WIDTH tail bits, newest in MSB
//
//  Revision    : 1.0 - initial release
// ============================================================================
module config_loader #(
    parameter int WORD_WIDTH   = 8,
    parameter int CHAIN_LENGTH = 100,
    parameter int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  config_data,
    output logic                  config_en,
    input  logic                  chain_out,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  bit_count,
    output logic [WORD_WIDTH-1:0] readback
);

    // bits_left never exceeds WORD_WIDTH
    localparam int c_BL_WIDTH = $clog2(WORD_WIDTH + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [CNT_WIDTH-1:0]  c_CHAIN_LEN = CNT_WIDTH'(CHAIN_LENGTH);
    localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [c_BL_WIDTH-1:0] c_BL_ONE    = c_BL_WIDTH'(1);
    localparam logic [c_BL_WIDTH-1:0] c_BL_WORD   = c_BL_WIDTH'(WORD_WIDTH);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [WORD_WIDTH-1:0] r_sreg;
    logic [c_BL_WIDTH-1:0] r_bits_left;
    logic [CNT_WIDTH-1:0]  r_bit_count;
    logic [WORD_WIDTH-1:0] r_readback;

    logic                  w_shift;
    logic [CNT_WIDTH-1:0]  w_bit_count_next;
    logic                  w_ready_cond;
    logic                  w_accept;
    logic                  w_start_ok;
    logic [CNT_WIDTH-1:0]  w_remaining;
    logic [c_BL_WIDTH-1:0] w_load_len;
    logic [WORD_WIDTH-1:0] w_readback_next;

    // ------------------------------------------------------------------
    // Datapath decode. Everything the chain sees is derived from
    // registers only, so the chain never has a combinational path from
    // the host inputs.
    // ------------------------------------------------------------------
    assign w_shift = (r_state == c_LOAD) && (r_bits_left != '0);

    // Count including the bit shifted on the coming edge; saturates so the
    // counter can never wrap even if the enable decode were ever extended.
    assign w_bit_count_next = (w_shift && (r_bit_count != c_CHAIN_LEN))
                            ? (r_bit_count + c_CNT_ONE) : r_bit_count;

    // Ready while the last bit of the current word is going out (or the
    // shifter is empty) so words can follow each other with no bubble.
    assign w_ready_cond = (r_bits_left <= c_BL_ONE) && (w_bit_count_next < c_CHAIN_LEN);

    assign w_accept   = (r_state == c_LOAD) && w_ready_cond && word_valid;
    assign w_start_ok = start && !abort && ((r_state == c_IDLE) || (r_state == c_DONE));

    // The final word is trimmed to the bits still owed to the chain; its
    // surplus upper bits are never shifted.
    assign w_remaining = c_CHAIN_LEN - w_bit_count_next;
    assign w_load_len  = (32'(w_remaining) >= 32'(WORD_WIDTH))
                       ? c_BL_WORD : c_BL_WIDTH'(w_remaining);

    generate
        if (WORD_WIDTH > 1) begin : g_rb_wide
            assign w_readback_next = {chain_out, r_readback[WORD_WIDTH-1:1]};
        end else begin : g_rb_single
            assign w_readback_next = chain_out;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        w_state_next = c_LOAD;
                    end
                end
                c_LOAD: begin
                    if (w_bit_count_next == c_CHAIN_LEN) begin
                        w_state_next = c_DONE;
                    end
                end
                default: begin
                    w_state_next = c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        config_en   = 1'b0;
        config_data = 1'b0;
        word_ready  = 1'b0;
        case (r_state)
            c_LOAD: begin
                busy        = 1'b1;
                config_en   = w_shift;
                config_data = r_sreg[0];
                word_ready  = w_ready_cond;
            end
            c_DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shifter, counters and readback capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg      <= '0;
            r_bits_left <= '0;
            r_bit_count <= '0;
            r_readback  <= '0;
        end else begin
            // The chain shifts on any edge where config_en was high, even
            // the edge that carries an abort, so the count and readback
            // track that shift too.
            if (w_shift) begin
                r_bit_count <= w_bit_count_next;
                r_readback  <= w_readback_next;
            end

            if (abort) begin
                // bit_count is kept for debug; the chain holds a partial load
                r_bits_left <= '0;
            end else if (w_start_ok) begin
                r_bit_count <= '0;
                r_bits_left <= '0;
            end else if (w_accept) begin
                r_sreg      <= word_in;
                r_bits_left <= w_load_len;
            end else if (w_shift) begin
                r_sreg      <= r_sreg >> 1;
                r_bits_left <= r_bits_left - c_BL_ONE;
            end
        end
    end

    assign bit_count = r_bit_count;
    assign readback  = r_readback;

endmodule
`default_nettype wire

// File: tb/tb_config_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_config_loader
//  Description : Self-checking bench for config_loader with a 20-bit modelled
//                configuration chain. Serial bits are checked against a
//                queue filled from the words the host hands over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_config_loader;

    localparam int WW = 8;
    localparam int CL = 20;
    localparam int CW = $clog2(CL + 1);

    typedef struct {
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] w2;
        int         gap;        // cycles word_valid held low once word 1 is wanted
        int         abort_at;   // abort when this many bits shifted (-1: never)
        int         exp_count;
        int         exp_done;
        int         exp_en;
        int         exp_low;    // enable-low cycles inside the shifting window
        int         exp_lat;    // edges from start edge to done
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          word_valid = 1'b0;
    logic [WW-1:0] word_in = '0;
    logic          word_ready;
    logic          config_data;
    logic          config_en;
    logic          chain_out;
    logic          busy;
    logic          done;
    logic [CW-1:0] bit_count;
    logic [WW-1:0] readback;

    logic [CL-1:0] chain = 20'hABCDE;

    int   tests = 0;
    int   fails = 0;
    int   edge_no = 0;
    int   en_cycles = 0;
    int   en_first = -1;
    int   en_last = -1;
    int   accepts = 0;
    int   pushed = 0;
    int   e0 = 0;
    int   done_edge = -1;
    int   abort_at = -1;
    int   aborted = 0;
    logic mid_start = 1'b0;
    logic ready_late = 1'b0;
    logic exp_bit;
    logic exp_q[$];

    vec_t vecs[5];

    always #5 clk = ~clk;

    assign chain_out = chain[0];

    config_loader #(
        .WORD_WIDTH   (WW),
        .CHAIN_LENGTH (CL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .config_data (config_data),
        .config_en   (config_en),
        .chain_out   (chain_out),
        .busy        (busy),
        .done        (done),
        .bit_count   (bit_count),
        .readback    (readback)
    );

    // Chain model and scoreboard, evaluated on pre-edge values.
    initial begin
        forever begin
            @(posedge clk);
            edge_no++;
            if (config_en === 1'b1) begin
                chain <= {config_data, chain[CL-1:1]};
                if (en_first < 0) en_first = edge_no;
                en_last = edge_no;
                en_cycles++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL serial_bit: unexpected shift with data %0b, required no shift", config_data);
                end else begin
                    exp_bit = exp_q.pop_front();
                    if (config_data !== exp_bit) begin
                        fails++;
                        $display("FAIL serial_bit: bit %0d got %0b, required %0b", en_cycles, config_data, exp_bit);
                    end
                end
            end
            if (word_valid && (word_ready === 1'b1)) begin
                accepts++;
                for (int i = 0; i < WW; i++) begin
                    if (pushed < CL) begin
                        exp_q.push_back(word_in[i]);
                        pushed++;
                    end
                end
            end else if ((word_ready === 1'b1) && accepts >= 3) begin
                ready_late = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        abort = 1'b0;
        start = mid_start && busy && (en_cycles == 5);
        if (done && done_edge < 0) done_edge = edge_no;
        if (abort_at >= 0 && aborted == 0 && en_cycles == abort_at && config_en) begin
            abort   = 1'b1;
            aborted = 1;
        end
    endtask

    task automatic start_load();
        exp_q.delete();
        pushed     = 0;
        accepts    = 0;
        en_cycles  = 0;
        en_first   = -1;
        en_last    = -1;
        ready_late = 1'b0;
        done_edge  = -1;
        aborted    = 0;
        start      = 1'b1;
        e0         = edge_no + 1;
        tick();
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        logic [7:0] w[3];
        int n;
        w[0] = v.w0;
        w[1] = v.w1;
        w[2] = v.w2;
        abort_at = v.abort_at;
        start_load();
        for (int k = 0; k < 3 && aborted == 0; k++) begin
            if (k == 1 && v.gap > 0) begin
                word_valid = 1'b0;
                for (int t = 0; t < 60 && word_ready !== 1'b1 && aborted == 0; t++) tick();
                for (int t = 0; t < v.gap && aborted == 0; t++) tick();
            end
            word_in    = w[k];
            word_valid = 1'b1;
            n = accepts;
            for (int t = 0; t < 60 && accepts == n && aborted == 0; t++) tick();
            if (accepts == n && aborted == 0) begin
                chk({tag, "_accept_timeout"}, 32'(accepts), 32'(n + 1));
            end
        end
        word_valid = 1'b0;
        for (int t = 0; t < 60 && done_edge < 0 && aborted == 0; t++) tick();
        tick();
        tick();
        if (aborted != 0) exp_q.delete();
        chk({tag, "_bit_count"}, 32'(bit_count), 32'(v.exp_count));
        chk({tag, "_done"}, 32'(done), 32'(v.exp_done));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_en_cycles"}, 32'(en_cycles), 32'(v.exp_en));
        chk({tag, "_en_low"}, 32'(en_last - en_first + 1 - en_cycles), 32'(v.exp_low));
        if (v.exp_done != 0) begin
            chk({tag, "_done_latency"}, 32'(done_edge - e0), 32'(v.exp_lat));
            chk({tag, "_bits_left_over"}, 32'(exp_q.size()), 32'd0);
            chk({tag, "_ready_after_last"}, 32'(ready_late), 32'd0);
        end else begin
            chk({tag, "_en_after_abort"}, 32'(config_en), 32'd0);
            chk({tag, "_ready_after_abort"}, 32'(word_ready), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 8'hFF, 0, -1, 20, 1, 20, 0, 21};
        vecs[1] = '{8'hA5, 8'h3C, 8'hFF, 5, -1, 20, 1, 20, 5, 26};
        vecs[2] = '{8'hA5, 8'h3C, 8'hFF, 0,  9, 10, 0, 10, 0, 0};
        vecs[3] = '{8'h00, 8'hFF, 8'h81, 2, -1, 20, 1, 20, 2, 23};
        vecs[4] = '{8'h5A, 8'hC3, 8'h0F, 0, -1, 20, 1, 20, 0, 21};

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_word_ready", 32'(word_ready), 32'd0);
        chk("rst_config_en", 32'(config_en), 32'd0);
        chk("rst_config_data", 32'(config_data), 32'd0);
        chk("rst_bit_count", 32'(bit_count), 32'd0);
        chk("rst_readback", 32'(readback), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // First load into the untouched chain: tail bits 19..12 of the
        // initial pattern come out last.
        run_vector(vecs[0], "load1");
        chk("load1_readback", 32'(readback), 32'hAB);

        // Start from DONE, with an ignored start pulse mid-load; the tail
        // now returns the first load's bits 19..12.
        mid_start = 1'b1;
        run_vector(vecs[0], "load2");
        mid_start = 1'b0;
        chk("load2_readback", 32'(readback), 32'hF3);

        // Asynchronous reset in the middle of shifting
        abort_at = -1;
        start_load();
        word_in    = 8'hA5;
        word_valid = 1'b1;
        repeat (4) tick();
        chk("midrst_en_before", 32'(config_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_config_en", 32'(config_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_word_ready", 32'(word_ready), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        word_valid = 1'b0;
        exp_q.delete();
        begin
            int held;
            held = en_cycles;
            repeat (3) tick();
            chk("midrst_no_shift", 32'(en_cycles), 32'(held));
        end
        rst_n = 1'b1;
        tick();
        chk("midrst_bit_count", 32'(bit_count), 32'd0);

        // Simultaneous start and abort from IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        tick();
        chk("start_abort_busy", 32'(busy), 32'd0);
        chk("start_abort_done", 32'(done), 32'd0);
        chk("start_abort_ready", 32'(word_ready), 32'd0);

        // Table-driven loads
        for (int i = 0; i < 5; i++) begin
            run_vector(vecs[i], $sformatf("vec%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
